// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and flow controller for the RV32I 5-stage pipeline.
// Generates per-stage hold/flush, PC redirects for taken jumps and traps, and
// sequences data-bus waits with a timeout trap and illegal-instruction traps.
// Optional build macro: HAZ_PERF_CNT_EN adds the stall_cnt_o counter port.
module pipe_hazard_ctrl #(
    parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid_i,
    input  logic        id_illegal_i,
    input  logic        id_rs1en_i,
    input  logic        id_rs2en_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        ex_rd_wen_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic        ex_is_load_i,
    input  logic        ex_jump_i,
    input  logic [31:0] ex_jump_addr_i,
    input  logic        mem_req_i,
    input  logic        mem_ack_i,
    output logic        hold_if_o,
    output logic        hold_id_o,
    output logic        hold_ex_o,
    output logic        hold_mem_o,
    output logic        flush_id_o,
    output logic        flush_ex_o,
    output logic        redirect_o,
    output logic [31:0] redirect_addr_o,
    output logic        trap_o,
`ifdef HAZ_PERF_CNT_EN
    output logic [31:0] stall_cnt_o,
`endif
    output logic [1:0]  trap_cause_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TRAP     = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_BUS_TO  = 2'b10;

    // Wait counter only needs to reach MEM_TIMEOUT-1 (MEM_TIMEOUT >= 2).
    localparam int               CNT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [1:0]       cause_nxt;

    logic        hold_if_c, hold_id_c, hold_ex_c, hold_mem_c;
    logic        flush_id_c, flush_ex_c, redirect_c, trap_c;
    logic [31:0] redirect_addr_c;
    logic        load_use;

    // Load-use: EX load writes a non-x0 register that ID reads (full 5-bit match).
    assign load_use = ex_is_load_i & ex_rd_wen_i & (ex_rd_addr_i != 5'd0) &
                      ((id_rs1en_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                       (id_rs2en_i & (id_rs2_addr_i == ex_rd_addr_i)));

    // Next-state and combinational control outputs from state plus inputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_nxt       = state;
        wait_cnt_nxt    = wait_cnt;
        cause_nxt       = trap_cause_o;
        hold_if_c       = 1'b0;
        hold_id_c       = 1'b0;
        hold_ex_c       = 1'b0;
        hold_mem_c      = 1'b0;
        flush_id_c      = 1'b0;
        flush_ex_c      = 1'b0;
        redirect_c      = 1'b0;
        redirect_addr_c = 32'h0;
        trap_c          = 1'b0;

        unique case (state)
            ST_RUN: begin
                if (mem_req_i && !mem_ack_i) begin
                    // Bus not ready: freeze the whole pipe and start counting.
                    {hold_if_c, hold_id_c, hold_ex_c, hold_mem_c} = 4'b1111;
                    state_nxt    = ST_MEM_WAIT;
                    wait_cnt_nxt = CNT_W'(1);
                end else if (ex_jump_i) begin
                    redirect_c      = 1'b1;
                    redirect_addr_c = ex_jump_addr_i;
                    flush_id_c      = 1'b1;
                    flush_ex_c      = 1'b1;
                end else if (id_valid_i && id_illegal_i) begin
                    // Keep the faulting instruction out of EX; trap next cycle.
                    hold_if_c  = 1'b1;
                    hold_id_c  = 1'b1;
                    flush_ex_c = 1'b1;
                    state_nxt  = ST_TRAP;
                    cause_nxt  = CAUSE_ILLEGAL;
                end else if (load_use) begin
                    // One bubble lets the load data reach the forwarding path.
                    hold_if_c  = 1'b1;
                    hold_id_c  = 1'b1;
                    flush_ex_c = 1'b1;
                end
            end

            ST_MEM_WAIT: begin
                if (mem_ack_i) begin
                    // Ack wins even on the timeout cycle.
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == CNT_LAST) begin
                    {hold_if_c, hold_id_c, hold_ex_c, hold_mem_c} = 4'b1111;
                    state_nxt    = ST_TRAP;
                    cause_nxt    = CAUSE_BUS_TO;
                    wait_cnt_nxt = '0;
                end else begin
                    {hold_if_c, hold_id_c, hold_ex_c, hold_mem_c} = 4'b1111;
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end

            ST_TRAP: begin
                redirect_c      = 1'b1;
                redirect_addr_c = TRAP_VEC;
                flush_id_c      = 1'b1;
                flush_ex_c      = 1'b1;
                trap_c          = 1'b1;
                state_nxt       = ST_RUN;
            end

            default: begin
                state_nxt    = ST_RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // FSM state, wait counter and registered trap cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            wait_cnt     <= '0;
            trap_cause_o <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state        <= state_nxt;
            wait_cnt     <= wait_cnt_nxt;
            trap_cause_o <= cause_nxt;
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign hold_if_o       = rst_n & hold_if_c;
    assign hold_id_o       = rst_n & hold_id_c;
    assign hold_ex_o       = rst_n & hold_ex_c;
    assign hold_mem_o      = rst_n & hold_mem_c;
    assign flush_id_o      = rst_n & flush_id_c;
    assign flush_ex_o      = rst_n & flush_ex_c;
    assign redirect_o      = rst_n & redirect_c;
    assign trap_o          = rst_n & trap_c;
    assign redirect_addr_o = rst_n ? redirect_addr_c : 32'h0;

`ifdef HAZ_PERF_CNT_EN
    // Count every cycle the IF/ID register is frozen; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= 32'h0;
        end else if (hold_id_o) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a sequential vector table (one
// entry per cycle, FSM state carries across entries) plus hand-written
// sequences for memory waits, bus timeout and reset corner cases.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic        id_valid;
        logic        id_illegal;
        logic        rs1en;
        logic        rs2en;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        ex_wen;
        logic [4:0]  rd;
        logic        ex_load;
        logic        ex_jump;
        logic [31:0] jaddr;
        logic        mem_req;
        logic        mem_ack;
    } in_t;

    typedef struct packed {
        logic [3:0]  hold;     // {if, id, ex, mem}
        logic [1:0]  flush;    // {id, ex}
        logic        redirect;
        logic [31:0] raddr;
        logic        trap;
        logic [1:0]  cause;
    } out_t;

    typedef struct {
        string name;
        in_t   stim;
        out_t  exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid_i, id_illegal_i, id_rs1en_i, id_rs2en_i;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
    logic        ex_rd_wen_i, ex_is_load_i, ex_jump_i;
    logic [31:0] ex_jump_addr_i;
    logic        mem_req_i, mem_ack_i;
    logic        hold_if_o, hold_id_o, hold_ex_o, hold_mem_o;
    logic        flush_id_o, flush_ex_o, redirect_o, trap_o;
    logic [31:0] redirect_addr_o;
    logic [1:0]  trap_cause_o;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    int n_total = 0;
    int n_pass  = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid_i      (id_valid_i),
        .id_illegal_i    (id_illegal_i),
        .id_rs1en_i      (id_rs1en_i),
        .id_rs2en_i      (id_rs2en_i),
        .id_rs1_addr_i   (id_rs1_addr_i),
        .id_rs2_addr_i   (id_rs2_addr_i),
        .ex_rd_wen_i     (ex_rd_wen_i),
        .ex_rd_addr_i    (ex_rd_addr_i),
        .ex_is_load_i    (ex_is_load_i),
        .ex_jump_i       (ex_jump_i),
        .ex_jump_addr_i  (ex_jump_addr_i),
        .mem_req_i       (mem_req_i),
        .mem_ack_i       (mem_ack_i),
        .hold_if_o       (hold_if_o),
        .hold_id_o       (hold_id_o),
        .hold_ex_o       (hold_ex_o),
        .hold_mem_o      (hold_mem_o),
        .flush_id_o      (flush_id_o),
        .flush_ex_o      (flush_ex_o),
        .redirect_o      (redirect_o),
        .redirect_addr_o (redirect_addr_o),
        .trap_o          (trap_o),
`ifdef HAZ_PERF_CNT_EN
        .stall_cnt_o     (stall_cnt_o),
`endif
        .trap_cause_o    (trap_cause_o)
    );

    task automatic drive(input in_t s);
        id_valid_i     = s.id_valid;
        id_illegal_i   = s.id_illegal;
        id_rs1en_i     = s.rs1en;
        id_rs2en_i     = s.rs2en;
        id_rs1_addr_i  = s.rs1;
        id_rs2_addr_i  = s.rs2;
        ex_rd_wen_i    = s.ex_wen;
        ex_rd_addr_i   = s.rd;
        ex_is_load_i   = s.ex_load;
        ex_jump_i      = s.ex_jump;
        ex_jump_addr_i = s.jaddr;
        mem_req_i      = s.mem_req;
        mem_ack_i      = s.mem_ack;
    endtask

    function automatic out_t sample();
        return {hold_if_o, hold_id_o, hold_ex_o, hold_mem_o, flush_id_o, flush_ex_o,
                redirect_o, redirect_addr_o, trap_o, trap_cause_o};
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got hold=%b flush=%b redir=%b addr=%h trap=%b cause=%b, want hold=%b flush=%b redir=%b addr=%h trap=%b cause=%b",
                     name, act.hold, act.flush, act.redirect, act.raddr, act.trap, act.cause,
                     exp.hold, exp.flush, exp.redirect, exp.raddr, exp.trap, exp.cause);
        else
            n_pass++;
    endtask

    // One cycle: drive at the falling edge, compare 1 ns later, state moves at the next rise.
    task automatic step(input string name, input in_t s, input out_t e);
        @(negedge clk);
        drive(s);
        #1;
        check(name, sample(), e);
    endtask

    task automatic add(input string n, input in_t s, input out_t e);
        vec_t v;
        v.name = n;
        v.stim = s;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    // Frequently used stimuli and expectations.
    function automatic in_t lw_x5(input logic rs1en, input logic [4:0] rs1,
                                  input logic rs2en, input logic [4:0] rs2);
        return in_t'{id_valid:1'b1, rs1en:rs1en, rs1:rs1, rs2en:rs2en, rs2:rs2,
                     ex_wen:1'b1, rd:5'd5, ex_load:1'b1, default:'0};
    endfunction

    function automatic out_t o_idle(input logic [1:0] c);
        return out_t'{cause:c, default:'0};
    endfunction

    function automatic out_t o_bubble(input logic [1:0] c);
        return out_t'{hold:4'b1100, flush:2'b01, cause:c, default:'0};
    endfunction

    function automatic out_t o_freeze(input logic [1:0] c);
        return out_t'{hold:4'b1111, cause:c, default:'0};
    endfunction

    function automatic out_t o_jump(input logic [31:0] a, input logic [1:0] c);
        return out_t'{flush:2'b11, redirect:1'b1, raddr:a, cause:c, default:'0};
    endfunction

    function automatic out_t o_trap(input logic [1:0] c);
        return out_t'{flush:2'b11, redirect:1'b1, raddr:32'h0000_0100, trap:1'b1,
                      cause:c, default:'0};
    endfunction

    localparam in_t IN_IDLE    = '0;
    localparam in_t IN_MISS    = in_t'{mem_req:1'b1, default:'0};
    localparam in_t IN_HIT     = in_t'{mem_req:1'b1, mem_ack:1'b1, default:'0};
    localparam in_t IN_ILLEGAL = in_t'{id_valid:1'b1, id_illegal:1'b1, default:'0};

    initial begin
        in_t s;

        // Reset asserted with busy inputs: every output must stay low.
        rst_n = 1'b0;
        drive(in_t'{ex_jump:1'b1, jaddr:32'h1234_5678, id_valid:1'b1, id_illegal:1'b1,
                    default:'0});
        @(negedge clk);
        #1;
        check("reset_outputs", sample(), o_idle(2'b00));
        @(negedge clk);
        drive(IN_IDLE);
        rst_n = 1'b1;

        // Sequential table: add x6,x5,x1 style cases, priorities, and MEM_WAIT entry/exit.
        add("idle",              IN_IDLE,                          o_idle(2'b00));
        add("load_use_rs1",      lw_x5(1'b1, 5'd5, 1'b1, 5'd1),    o_bubble(2'b00));
        s = lw_x5(1'b1, 5'd5, 1'b1, 5'd1); s.ex_load = 1'b0; s.ex_wen = 1'b0;
        add("after_bubble",      s,                                o_idle(2'b00));
        s = lw_x5(1'b1, 5'd0, 1'b0, 5'd0); s.rd = 5'd0;
        add("load_rd_x0",        s,                                o_idle(2'b00));
        add("rs2_disabled",      lw_x5(1'b1, 5'd1, 1'b0, 5'd5),    o_idle(2'b00));
        add("load_use_rs2",      lw_x5(1'b1, 5'd1, 1'b1, 5'd5),    o_bubble(2'b00));
        s = lw_x5(1'b1, 5'd5, 1'b0, 5'd0); s.ex_wen = 1'b0;
        add("load_no_wen",       s,                                o_idle(2'b00));
        s = lw_x5(1'b1, 5'd5, 1'b0, 5'd0); s.ex_load = 1'b0;
        add("alu_not_load",      s,                                o_idle(2'b00));
        s = lw_x5(1'b1, 5'd5, 1'b1, 5'd5); s.rd = 5'd21;
        add("rd_msb_differs",    s,                                o_idle(2'b00));
        add("jump",              in_t'{ex_jump:1'b1, jaddr:32'h0000_2468, default:'0},
                                 o_jump(32'h0000_2468, 2'b00));
        add("jump_over_illegal", in_t'{ex_jump:1'b1, jaddr:32'hDEAD_BEE0, id_valid:1'b1,
                                       id_illegal:1'b1, default:'0},
                                 o_jump(32'hDEAD_BEE0, 2'b00));
        s = lw_x5(1'b1, 5'd5, 1'b0, 5'd0); s.ex_jump = 1'b1; s.jaddr = 32'h0000_0040;
        add("jump_over_loaduse", s,                                o_jump(32'h0000_0040, 2'b00));
        s = lw_x5(1'b1, 5'd5, 1'b0, 5'd0); s.mem_req = 1'b1; s.mem_ack = 1'b1;
        add("zero_wait_loaduse", s,                                o_bubble(2'b00));
        add("illegal",           IN_ILLEGAL,                       o_bubble(2'b00));
        add("illegal_trap",      in_t'{ex_jump:1'b1, jaddr:32'h0000_0888, default:'0},
                                 o_trap(2'b01));
        add("after_trap",        IN_IDLE,                          o_idle(2'b01));
        add("illegal_not_valid", in_t'{id_illegal:1'b1, default:'0}, o_idle(2'b01));
        add("miss_beats_jump",   in_t'{mem_req:1'b1, ex_jump:1'b1, jaddr:32'h0000_0444,
                                       id_valid:1'b1, id_illegal:1'b1, default:'0},
                                 o_freeze(2'b01));
        s = lw_x5(1'b1, 5'd5, 1'b0, 5'd0); s.ex_jump = 1'b1; s.id_illegal = 1'b1;
        add("wait_ignores_all",  s,                                o_freeze(2'b01));
        add("wait_ack",          IN_HIT,                           o_idle(2'b01));
        add("run_after_ack",     in_t'{ex_jump:1'b1, jaddr:32'h0000_1000, default:'0},
                                 o_jump(32'h0000_1000, 2'b01));

        foreach (vecs[i]) step(vecs[i].name, vecs[i].stim, vecs[i].exp);

        // Ack arriving on the third cycle of the access.
        step("ack3_miss",  IN_MISS, o_freeze(2'b01));
        step("ack3_wait",  IN_MISS, o_freeze(2'b01));
        step("ack3_ack",   IN_HIT,  o_idle(2'b01));
        step("ack3_run",   in_t'{ex_jump:1'b1, jaddr:32'h0000_0c00, default:'0},
             o_jump(32'h0000_0c00, 2'b01));

        // No ack: 16 frozen cycles, then the bus-timeout trap.
        for (int i = 0; i < 16; i++) step($sformatf("timeout_hold_%0d", i), IN_MISS, o_freeze(2'b01));
        step("timeout_trap",  IN_MISS, o_trap(2'b10));
        step("timeout_after", IN_IDLE, o_idle(2'b10));

        // Ack on the last allowed cycle beats the timeout.
        for (int i = 0; i < 15; i++) step($sformatf("lastack_hold_%0d", i), IN_MISS, o_freeze(2'b10));
        step("lastack_ack",   IN_HIT,  o_idle(2'b10));
        step("lastack_notrap", IN_IDLE, o_idle(2'b10));

        // Reset in the middle of a wait returns straight to RUN and clears the cause.
        step("rst_wait_miss", IN_MISS, o_freeze(2'b10));
        step("rst_wait_wait", IN_MISS, o_freeze(2'b10));
        @(negedge clk);
        rst_n = 1'b0;
        drive(in_t'{mem_req:1'b1, ex_jump:1'b1, jaddr:32'h0000_0abc, default:'0});
        #1;
        check("rst_mid_wait", sample(), o_idle(2'b00));
        @(negedge clk);
        drive(IN_IDLE);
        rst_n = 1'b1;
        step("rst_back_run", in_t'{ex_jump:1'b1, jaddr:32'h0000_0abc, default:'0},
             o_jump(32'h0000_0abc, 2'b00));

        // Reset while a trap is pending discards it.
        step("rst_trap_illegal", IN_ILLEGAL, o_bubble(2'b00));
        @(negedge clk);
        rst_n = 1'b0;
        drive(IN_IDLE);
        #1;
        check("rst_in_trap", sample(), o_idle(2'b00));
        @(negedge clk);
        rst_n = 1'b1;
        step("rst_trap_gone", IN_IDLE, o_idle(2'b00));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
